count_uart_tx: RTL and testbench
================================

COUNT_UART_TX -- requirements
Module: count_uart_tx

Interface
REQ-001 Parameter CLK_HZ, default 12000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 clk_12m  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 send  input  1  request to transmit value; sampled each cycle.
REQ-006 value  input  8  unsigned count to transmit, sampled only on the accept cycle.
REQ-007 busy  output  1  high while a message is in progress.
REQ-008 tx  output  1  UART line, idle high.

Function
REQ-009 The block SHALL derive BAUD_DIV = CLK_HZ/BAUD with integer division (104 at defaults); each transmitted bit SHALL last exactly BAUD_DIV cycles.
REQ-010 A request SHALL be accepted on a cycle where send=1 and busy=0; value SHALL be latched on that cycle.
REQ-011 send while busy=1 SHALL be ignored, with no queueing and no effect on the message in flight.
REQ-012 busy SHALL rise the cycle after accept and fall the cycle after the last stop bit ends; send in the first busy=0 cycle SHALL be accepted.
REQ-013 The message SHALL be the ASCII decimal digits of value with leading zeros suppressed (ones digit always sent), followed by LF (0x0A).
REQ-014 Digits SHALL be ASCII 0x30+d; hundreds range 0-2, tens 0-9, ones 0-9; messages are 2 to 4 bytes long.
REQ-015 Each byte SHALL be framed 8N1: one start bit (0), eight data bits LSB first, one stop bit (1).
REQ-016 The FSM SHALL have states IDLE, LOAD, START, DATA, STOP.
REQ-017 Transitions: IDLE->LOAD on accept; LOAD->START after one cycle (digit conversion); START->DATA and DATA->STOP after bit timing; STOP->START if bytes remain, else STOP->IDLE.
REQ-018 The start bit of the first byte SHALL begin two cycles after accept (LOAD occupies one cycle).
REQ-019 Consecutive bytes SHALL have zero gap: the next start bit follows the stop bit immediately.
REQ-020 tx SHALL be 1 in IDLE and LOAD; it SHALL never glitch within a bit period.

Reset
REQ-021 On rst=1: tx=1, busy=0, state=IDLE, and the baud counter, bit index and byte index SHALL be cleared, effective at the next edge.
REQ-022 rst mid-frame SHALL abort the message; tx SHALL return high on the next edge, and no partial bytes SHALL resume after rst deasserts.
REQ-023 rst SHALL take priority over send in the same cycle.

Configuration
REQ-024 Macro COUNT_TX_CRLF_EN: when defined, CR (0x0D) SHALL precede LF, giving messages of 3 to 5 bytes.
REQ-025 Without COUNT_TX_CRLF_EN, only LF SHALL terminate the message; the interface SHALL be identical in both builds.

Structure
REQ-026 Package count_tx_pkg SHALL hold the state enum, ASCII constants (ASCII_ZERO, ASCII_LF, ASCII_CR) and the BAUD_DIV calculation function.
REQ-027 Byte serialization SHALL be a sub-module uart_tx_byte with a valid/ready byte input, the tx output and its own baud counter.
REQ-028 count_uart_tx SHALL own digit conversion, message sequencing and the busy output.

Verification
REQ-029 value=0, send pulse -> tx bytes 0x30, 0x0A; busy high for 2*10*104 cycles plus 1 LOAD cycle.
REQ-030 value=42 -> bytes 0x34, 0x32, 0x0A; value=255 -> bytes 0x32, 0x35, 0x35, 0x0A; each bit measured at exactly 104 cycles.
REQ-031 send held high for the whole message with value changing -> exactly one message containing the value latched at accept; a new message starts on the first cycle busy=0.
REQ-032 rst pulse during the second data bit of the first byte -> tx=1 and busy=0 at the next edge, and no further falling edge until the next send.
REQ-033 Build with COUNT_TX_CRLF_EN, value=7 -> bytes 0x37, 0x0D, 0x0A.
REQ-034 send and rst both high in the same cycle -> no message, tx stays 1.

Source files
------------

// File: rtl/count_tx_pkg.sv
// Shared types, ASCII constants and baud-divider helper for the count UART transmitter.
package count_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  function automatic int calc_baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with valid/ready input; accepts the next byte during the
// last stop-bit cycle so back-to-back bytes leave no idle gap.
module uart_tx_byte
  import count_tx_pkg::*;
#(
  parameter int BAUD_DIV = 104
) (
  input  logic       clk_12m,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx,
  output tx_state_e  state_next
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  tx_state_e        state_reg;
  logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             bit_end;

  assign bit_end    = (baud_cnt_reg == CNT_W'(BAUD_DIV - 1));
  assign byte_ready = (state_reg == IDLE) || ((state_reg == STOP) && bit_end);
  assign tx         = tx_reg;

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = bit_end ? '0 : baud_cnt_reg + 1'b1;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    tx_next       = tx_reg;
    case (state_reg)
      IDLE: begin
        baud_cnt_next = '0;
        if (byte_valid) begin
          state_next = START;
          shift_next = byte_data;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
          tx_next      = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_valid) begin
            state_next = START;
            shift_next = byte_data;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        baud_cnt_next = '0;
        tx_next       = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_12m) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// Sends an 8-bit count as ASCII decimal (no leading zeros) followed by LF over UART.
// Define COUNT_TX_CRLF_EN to insert CR before the LF.
module count_uart_tx
  import count_tx_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_12m,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] value,
  output logic       busy,
  output logic       tx
);

  localparam int BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
`ifdef COUNT_TX_CRLF_EN
  localparam logic [2:0] TERM_LEN = 3'd2;
`else
  localparam logic [2:0] TERM_LEN = 3'd1;
`endif

  tx_state_e  state_reg, state_next, ser_state_next;
  logic [7:0] value_reg, value_next;
  logic [2:0] idx_reg, idx_next;
  logic [3:0] hundreds, tens, ones;
  logic [2:0] ndig, msg_len;
  logic [7:0] digit_seq [3];
  logic [7:0] msg_byte [8];
  logic       byte_valid, byte_ready;

  assign hundreds = 4'(value_reg / 8'd100);
  assign tens     = 4'((value_reg / 8'd10) % 8'd10);
  assign ones     = 4'(value_reg % 8'd10);
  assign ndig     = (value_reg >= 8'd100) ? 3'd3 : (value_reg >= 8'd10) ? 3'd2 : 3'd1;
  assign msg_len  = ndig + TERM_LEN;

  // Digits left-justified so the most significant non-zero digit goes first.
  always_comb begin
    digit_seq[0] = ascii_digit(ones);
    digit_seq[1] = ascii_digit(ones);
    digit_seq[2] = ascii_digit(ones);
    if (ndig == 3'd3) begin
      digit_seq[0] = ascii_digit(hundreds);
      digit_seq[1] = ascii_digit(tens);
    end else if (ndig == 3'd2) begin
      digit_seq[0] = ascii_digit(tens);
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_msg
    logic [7:0] term_byte;
`ifdef COUNT_TX_CRLF_EN
    assign term_byte = (3'(gi) == ndig) ? ASCII_CR : ASCII_LF;
`else
    assign term_byte = ASCII_LF;
`endif
    if (gi < 3) begin : g_dig
      assign msg_byte[gi] = (3'(gi) < ndig) ? digit_seq[gi] : term_byte;
    end else begin : g_term
      assign msg_byte[gi] = term_byte;
    end
  end

  assign byte_valid = (state_reg != IDLE) && (idx_reg < msg_len);
  assign busy       = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    value_next = value_reg;
    idx_next   = idx_reg;
    if (byte_valid && byte_ready) begin
      idx_next = idx_reg + 3'd1;
    end
    case (state_reg)
      IDLE: begin
        if (send) begin
          state_next = LOAD;
          value_next = value;
          idx_next   = 3'd0;
        end
      end
      LOAD:              state_next = START;
      // Bit-level phases follow the serializer, which owns the baud timing.
      START, DATA, STOP: state_next = ser_state_next;
      default:           state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_12m) begin
    if (rst) begin
      state_reg <= IDLE;
      value_reg <= 8'h00;
      idx_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      value_reg <= value_next;
      idx_reg   <= idx_next;
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx_byte (
    .clk_12m   (clk_12m),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (msg_byte[idx_reg]),
    .byte_ready(byte_ready),
    .tx        (tx),
    .state_next(ser_state_next)
  );

endmodule

// File: tb/tb_count_uart_tx.sv
// Scoreboard bench for count_uart_tx: expected bytes queued at accept, UART monitor checks frames.
module tb_count_uart_tx;

  localparam int BAUD_DIV = 12000000 / 115200;
  localparam int BIT_FRAME = 10 * BAUD_DIV;
  localparam int BUDGET = 8000;

  typedef struct {
    logic [7:0] data;
    bit         last;
  } exp_t;

  logic       clk_12m = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] value;
  logic       busy;
  logic       tx;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   fall_cnt = 0;
  logic tx_prev = 1'b1;
  bit   mon_en = 1'b1;

  count_uart_tx dut (
    .clk_12m(clk_12m),
    .rst    (rst),
    .send   (send),
    .value  (value),
    .busy   (busy),
    .tx     (tx)
  );

  initial forever #5 clk_12m = ~clk_12m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Reference message: decimal text of the value, then terminator.
  task automatic push_msg(input logic [7:0] v, output int len);
    string s;
    exp_t  e;
    s   = $sformatf("%0d", v);
    len = 0;
    for (int i = 0; i < s.len(); i++) begin
      e.data = s[i];
      e.last = 1'b0;
      exp_q.push_back(e);
      len++;
    end
`ifdef COUNT_TX_CRLF_EN
    e.data = 8'h0D;
    e.last = 1'b0;
    exp_q.push_back(e);
    len++;
`endif
    e.data = 8'h0A;
    e.last = 1'b1;
    exp_q.push_back(e);
    len++;
    $display("tx request value=%0d bytes=%0d", v, len);
  endtask

  initial forever begin
    @(negedge clk_12m);
    if (tx_prev === 1'b1 && tx === 1'b0) fall_cnt++;
    tx_prev = tx;
  end

  // UART monitor: samples first and last cycle of every bit period.
  initial begin : monitor
    exp_t       e;
    logic [9:0] frame, rx_a, rx_b;
    bit         carry;
    carry = 1'b0;
    forever begin
      if (!carry) @(negedge clk_12m);
      carry = 1'b0;
      if (mon_en && tx === 1'b0) begin
        check("rx_byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() == 0) begin
          repeat (BIT_FRAME) @(negedge clk_12m);
        end else begin
          e     = exp_q.pop_front();
          frame = {1'b1, e.data, 1'b0};
          for (int k = 0; k < 10; k++) begin
            rx_a[k] = tx;
            repeat (BAUD_DIV - 1) @(negedge clk_12m);
            rx_b[k] = tx;
            if (k < 9) @(negedge clk_12m);
          end
          $display("rx byte 0x%02h expected 0x%02h", rx_a[8:1], e.data);
          check("frame_bit_start", 32'(rx_a), 32'(frame));
          check("frame_bit_end", 32'(rx_b), 32'(frame));
          if (!e.last) begin
            @(negedge clk_12m);
            check("zero_gap_start", 32'(tx), 0);
            carry = (tx === 1'b0);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < BUDGET) begin
      @(negedge clk_12m);
      n++;
    end
    if (n >= BUDGET) check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic measure_busy(input int len, input string name);
    int cnt;
    cnt = 1;
    while (cnt < BUDGET) begin
      @(negedge clk_12m);
      if (busy === 1'b1) cnt++;
      else break;
    end
    check(name, cnt, 1 + BIT_FRAME * len);
  endtask

  task automatic run_msg(input logic [7:0] v);
    int len;
    wait_idle();
    send  = 1'b1;
    value = v;
    @(posedge clk_12m);
    if (mon_en) push_msg(v, len);
    @(negedge clk_12m);
    send  = 1'b0;
    value = 8'($urandom);
    check("busy_rise", 32'(busy), 1);
    measure_busy(len, "busy_length");
  endtask

  task automatic run_held(input logic [7:0] v1, input logic [7:0] v2);
    int len1, len2, cnt;
    wait_idle();
    send  = 1'b1;
    value = v1;
    @(posedge clk_12m);
    push_msg(v1, len1);
    cnt = 0;
    while (cnt < BUDGET) begin
      @(negedge clk_12m);
      if (busy === 1'b1) begin
        cnt++;
        value = 8'($urandom);
      end else break;
    end
    check("held_busy_length", cnt, 1 + BIT_FRAME * len1);
    value = v2;
    @(posedge clk_12m);
    push_msg(v2, len2);
    @(negedge clk_12m);
    send = 1'b0;
    check("held_reaccept", 32'(busy), 1);
    measure_busy(len2, "held_second_length");
  endtask

  initial begin : stim
    int    f0;
    string s;
    logic [7:0] c;
    rst   = 1'b1;
    send  = 1'b0;
    value = 8'h00;
    repeat (4) @(negedge clk_12m);
    check("reset_tx", 32'(tx), 1);
    check("reset_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk_12m);

    run_msg(8'd0);
    run_msg(8'd42);
    run_msg(8'd255);
    run_msg(8'd7);
    run_msg(8'd10);
    run_msg(8'd99);
    run_msg(8'd100);
    for (int i = 0; i < 5; i++) run_msg(8'($urandom_range(0, 255)));
    run_held(8'd13, 8'($urandom_range(0, 255)));

    // Reset during data bit 1 of the first byte of "45".
    wait_idle();
    mon_en = 1'b0;
    send   = 1'b1;
    value  = 8'd45;
    @(posedge clk_12m);
    @(negedge clk_12m);
    send = 1'b0;
    repeat (259) @(negedge clk_12m);
    s = $sformatf("%0d", 45);
    c = s[0];
    check("pre_rst_data_bit1", 32'(tx), 32'(c[1]));
    rst = 1'b1;
    @(negedge clk_12m);
    rst = 1'b0;
    check("rst_mid_tx", 32'(tx), 1);
    check("rst_mid_busy", 32'(busy), 0);
    f0 = fall_cnt;
    repeat (3 * BIT_FRAME) @(negedge clk_12m);
    check("rst_no_resume", fall_cnt - f0, 0);
    mon_en = 1'b1;

    // rst and send together: no message.
    rst   = 1'b1;
    send  = 1'b1;
    value = 8'($urandom);
    @(negedge clk_12m);
    rst  = 1'b0;
    send = 1'b0;
    check("rst_send_busy", 32'(busy), 0);
    check("rst_send_tx", 32'(tx), 1);
    f0 = fall_cnt;
    repeat (300) @(negedge clk_12m);
    check("rst_send_quiet", fall_cnt - f0, 0);

    run_msg(8'($urandom_range(0, 255)));
    wait_idle();
    repeat (5) @(negedge clk_12m);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
